// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - state encoding, RV32I opcode constants and legality check for multicycle_seq
package seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } seq_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic is_legal_opcode(input logic [6:0] opc);
    logic legal;
    legal = 1'b0;
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - 8-bit MEM-state wait counter; hit flags the last permitted wait cycle
module mem_wait_timer #(
  parameter int unsigned MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  // hit fires in the MAX-th enabled cycle, i.e. while the count still reads MAX-1
  localparam logic [7:0] HIT_VAL = 8'(MAX - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = en && (cnt_q == HIT_VAL);

endmodule

// File: rtl/multicycle_seq.sv
// rtl/multicycle_seq.sv - FETCH/DECODE/EXEC/MEM/WB sequencer gating the RV32I datapath strobes
// Optional cycle/instret performance counters are built when SEQ_PERF_CNT_EN is defined.
module multicycle_seq
  import seq_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
`ifdef SEQ_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [6:0]         opcode,
  input  logic               rfwenable,
  input  logic               dmwen,
  input  logic               useDM,
  input  logic               dm_ready,
  output logic               ir_en,
  output logic               pc_en,
  output logic               rf_wen,
  output logic               dm_req,
  output logic               dm_wen,
  output logic               busy,
  output logic               halted,
  output logic               illegal,
  output logic               timeout,
  output logic [STATE_W-1:0] state
`ifdef SEQ_PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_cnt
  , output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam logic [STATE_W-1:0] ST_IDLE   = S_IDLE;
  localparam logic [STATE_W-1:0] ST_FETCH  = S_FETCH;
  localparam logic [STATE_W-1:0] ST_DECODE = S_DECODE;
  localparam logic [STATE_W-1:0] ST_EXEC   = S_EXEC;
  localparam logic [STATE_W-1:0] ST_MEM    = S_MEM;
  localparam logic [STATE_W-1:0] ST_WB     = S_WB;
  localparam logic [STATE_W-1:0] ST_HALT   = S_HALT;
  localparam logic [STATE_W-1:0] ST_TRAP   = S_TRAP;

  logic [STATE_W-1:0] state_q, state_d;
  logic               halted_q, halted_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic               in_mem;
  logic               wait_hit;

  assign in_mem = (state_q == ST_MEM);

  mem_wait_timer #(
    .MAX (MEM_WAIT_MAX)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .clr   (!in_mem || dm_ready),
    .en    (in_mem),
    .hit   (wait_hit)
  );

  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (opcode == OPC_SYSTEM) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else if (!is_legal_opcode(opcode)) begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = useDM ? ST_MEM : ST_WB;
      // dm_ready is checked first so a completion on the last wait cycle still retires
      ST_MEM: begin
        if (dm_ready) begin
          state_d = ST_WB;
        end else if (wait_hit) begin
          state_d   = ST_TRAP;
          timeout_d = 1'b1;
        end
      end
      ST_WB: state_d = run ? ST_FETCH : ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Strobes are decoded from the registered state; the store strobe also waits for dm_ready
  assign ir_en   = (state_q == ST_FETCH);
  assign pc_en   = (state_q == ST_WB);
  assign rf_wen  = (state_q == ST_WB) && rfwenable;
  assign dm_req  = in_mem;
  assign dm_wen  = in_mem && dmwen && dm_ready;
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_TRAP);
  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state   = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

  always_comb begin
    cycle_cnt_d   = busy ? cycle_cnt_q + CNT_W'(1) : cycle_cnt_q;
    instret_cnt_d = (state_q == ST_WB) ? instret_cnt_q + CNT_W'(1) : instret_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_seq.sv
// tb/tb_multicycle_seq.sv - scoreboard bench for multicycle_seq using hand-written per-cycle traces
module tb_multicycle_seq;

  localparam logic [2:0] E_IDLE = 3'd0, E_FETCH = 3'd1, E_DECODE = 3'd2, E_EXEC = 3'd3;
  localparam logic [2:0] E_MEM = 3'd4, E_WB = 3'd5, E_HALT = 3'd6, E_TRAP = 3'd7;

  // {ir_en, pc_en, rf_wen, dm_req, dm_wen, busy, halted, illegal, timeout}
  localparam logic [8:0] F_NONE   = 9'b000000000;
  localparam logic [8:0] F_FETCH  = 9'b100001000;
  localparam logic [8:0] F_BUSY   = 9'b000001000;
  localparam logic [8:0] F_WB_RF  = 9'b011001000;
  localparam logic [8:0] F_WB     = 9'b010001000;
  localparam logic [8:0] F_MEM    = 9'b000101000;
  localparam logic [8:0] F_MEM_WR = 9'b000111000;
  localparam logic [8:0] F_HALT   = 9'b000000100;
  localparam logic [8:0] F_ILL    = 9'b000000010;
  localparam logic [8:0] F_TO     = 9'b000000001;

  localparam logic [6:0] ADD = 7'b0110011, SW = 7'b0100011, LW = 7'b0000011;
  localparam logic [6:0] ECALL = 7'b1110011, BAD = 7'b0001011;

  logic       clk = 1'b0;
  logic       reset, run, rfwenable, dmwen, useDM, dm_ready;
  logic [6:0] opcode;
  logic       ir_en, pc_en, rf_wen, dm_req, dm_wen, busy, halted, illegal, timeout;
  logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  string       nm_q[$];
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_seq #(
    .MEM_WAIT_MAX (15)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .opcode    (opcode),
    .rfwenable (rfwenable),
    .dmwen     (dmwen),
    .useDM     (useDM),
    .dm_ready  (dm_ready),
    .ir_en     (ir_en),
    .pc_en     (pc_en),
    .rf_wen    (rf_wen),
    .dm_req    (dm_req),
    .dm_wen    (dm_wen),
    .busy      (busy),
    .halted    (halted),
    .illegal   (illegal),
    .timeout   (timeout),
    .state     (state)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_cnt   (cycle_cnt)
    , .instret_cnt (instret_cnt)
`endif
  );

  // Monitor: compare the DUT outputs against the expected entry queued for this cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [11:0] e, a;
      string       n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = {state, ir_en, pc_en, rf_wen, dm_req, dm_wen, busy, halted, illegal, timeout};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got state=%0d flags=%b, expected state=%0d flags=%b",
                 n, a[11:9], a[8:0], e[11:9], e[8:0]);
      end
    end
  end

  task automatic cyc(input string nm, input logic [2:0] st, input logic [8:0] fl);
    nm_q.push_back(nm);
    exp_q.push_back({st, fl});
    @(posedge clk);
    #1;
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic chk_cnt(input string nm, input logic [31:0] cyc_e, input logic [31:0] ret_e);
    n_tests++;
    if (cycle_cnt !== cyc_e || instret_cnt !== ret_e) begin
      n_fail++;
      $display("FAIL %s: got cycle_cnt=%0d instret_cnt=%0d, expected %0d/%0d",
               nm, cycle_cnt, instret_cnt, cyc_e, ret_e);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b0; opcode = 7'd0; rfwenable = 1'b0;
    dmwen = 1'b0; useDM = 1'b0; dm_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc("reset_state", E_IDLE, F_NONE);

    // ADD: FETCH cycle 1, WB cycle 4, FETCH again cycle 5
    run = 1'b1; opcode = ADD; rfwenable = 1'b1;
    cyc("add_idle", E_IDLE, F_NONE);
    cyc("add_fetch", E_FETCH, F_FETCH);
    cyc("add_decode", E_DECODE, F_BUSY);
    cyc("add_exec", E_EXEC, F_BUSY);
    cyc("add_wb", E_WB, F_WB_RF);

`ifdef SEQ_PERF_CNT_EN
    chk_cnt("perf_after_add", 32'd4, 32'd1);
`endif
    // SW with three wait cycles; the store strobe only on the 4th MEM cycle
    opcode = SW; rfwenable = 1'b0; dmwen = 1'b1; useDM = 1'b1; dm_ready = 1'b0;
    cyc("sw_fetch", E_FETCH, F_FETCH);
    cyc("sw_decode", E_DECODE, F_BUSY);
    cyc("sw_exec", E_EXEC, F_BUSY);
    cyc("sw_mem1", E_MEM, F_MEM);
    cyc("sw_mem2", E_MEM, F_MEM);
    cyc("sw_mem3", E_MEM, F_MEM);
    dm_ready = 1'b1;
    cyc("sw_mem4_write", E_MEM, F_MEM_WR);
    dm_ready = 1'b0; run = 1'b0;
    cyc("sw_wb_no_rf", E_WB, F_WB);
    cyc("run_drop_idle", E_IDLE, F_NONE);

    // LW with dm_ready low: 15 MEM cycles, then TRAP with timeout
    run = 1'b1; opcode = LW; dmwen = 1'b0; rfwenable = 1'b1; useDM = 1'b1;
    cyc("lw_to_idle", E_IDLE, F_NONE);
    cyc("lw_to_fetch", E_FETCH, F_FETCH);
    cyc("lw_to_decode", E_DECODE, F_BUSY);
    cyc("lw_to_exec", E_EXEC, F_BUSY);
    for (int i = 1; i <= 15; i++) cyc($sformatf("lw_to_mem%0d", i), E_MEM, F_MEM);
    run = 1'b0;
    cyc("lw_trap", E_TRAP, F_TO);
    run = 1'b1;
    cyc("lw_trap_hold", E_TRAP, F_TO);
    reset = 1'b1;
    cyc("lw_trap_reset_cycle", E_TRAP, F_TO);
    reset = 1'b0; run = 1'b0;
    cyc("lw_after_reset", E_IDLE, F_NONE);

    // dm_ready arriving on the 15th MEM cycle beats the timeout
    run = 1'b1;
    cyc("lw_edge_idle", E_IDLE, F_NONE);
    cyc("lw_edge_fetch", E_FETCH, F_FETCH);
    cyc("lw_edge_decode", E_DECODE, F_BUSY);
    cyc("lw_edge_exec", E_EXEC, F_BUSY);
    for (int i = 1; i <= 14; i++) cyc($sformatf("lw_edge_mem%0d", i), E_MEM, F_MEM);
    dm_ready = 1'b1;
    cyc("lw_edge_mem15_ready", E_MEM, F_MEM);
    dm_ready = 1'b0; run = 1'b0;
    cyc("lw_edge_wb", E_WB, F_WB_RF);
    cyc("lw_edge_idle_after", E_IDLE, F_NONE);

    // Illegal opcode traps straight from DECODE
    run = 1'b1; opcode = BAD; rfwenable = 1'b1; dmwen = 1'b1; useDM = 1'b1; dm_ready = 1'b1;
    cyc("ill_idle", E_IDLE, F_NONE);
    cyc("ill_fetch", E_FETCH, F_FETCH);
    cyc("ill_decode", E_DECODE, F_BUSY);
    cyc("ill_trap", E_TRAP, F_ILL);
    cyc("ill_trap_hold", E_TRAP, F_ILL);
    reset = 1'b1;
    cyc("ill_reset_cycle", E_TRAP, F_ILL);
    reset = 1'b0; run = 1'b0; dm_ready = 1'b0;
    cyc("ill_after_reset", E_IDLE, F_NONE);

    // ECALL halts; run is ignored until reset
    run = 1'b1; opcode = ECALL; rfwenable = 1'b0; dmwen = 1'b0; useDM = 1'b0;
    cyc("ecall_idle", E_IDLE, F_NONE);
    cyc("ecall_fetch", E_FETCH, F_FETCH);
    cyc("ecall_decode", E_DECODE, F_BUSY);
    cyc("ecall_halt", E_HALT, F_HALT);
    run = 1'b0;
    cyc("ecall_halt_run0", E_HALT, F_HALT);
    run = 1'b1;
    cyc("ecall_halt_run1", E_HALT, F_HALT);
    reset = 1'b1;
    cyc("ecall_reset_cycle", E_HALT, F_HALT);
    reset = 1'b0; run = 1'b0;
    cyc("ecall_after_reset", E_IDLE, F_NONE);

    // Reset during MEM of a store with dm_ready low: no write, IDLE next
    run = 1'b1; opcode = SW; dmwen = 1'b1; useDM = 1'b1; dm_ready = 1'b0;
    cyc("rst_mem_idle", E_IDLE, F_NONE);
    cyc("rst_mem_fetch", E_FETCH, F_FETCH);
    cyc("rst_mem_decode", E_DECODE, F_BUSY);
    cyc("rst_mem_exec", E_EXEC, F_BUSY);
    cyc("rst_mem_mem1", E_MEM, F_MEM);
    reset = 1'b1;
    cyc("rst_mem_reset_cycle", E_MEM, F_MEM);
    reset = 1'b0; run = 1'b0;
`ifdef SEQ_PERF_CNT_EN
    chk_cnt("perf_after_reset", 32'd0, 32'd0);
`endif
    cyc("rst_mem_after", E_IDLE, F_NONE);
    cyc("rst_mem_stays_idle", E_IDLE, F_NONE);

    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
